// File: rtl/control_pipeline_pkg.sv
// Shared types for the ID->EX->MEM->WB control pipeline and its ECALL halt sequencer.
// Each stage carries only the control fields that stage or a later one consumes.
package control_pipeline_pkg;

    typedef enum logic [1:0] {
        HALT_RUN     = 2'd0,
        HALT_DRAIN   = 2'd1,
        HALT_HALTED  = 2'd2
    } halt_state_e;

    typedef struct packed {
        logic       is_jal;
        logic       is_jalr;
        logic       branch;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       pc_to_reg;
        logic       write_enable;
        logic       halt_mark;
        logic [6:0] alu_op;
        logic [4:0] rd;
    } ex_ctrl_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       pc_to_reg;
        logic       write_enable;
        logic       halt_mark;
        logic [4:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic       mem_to_reg;
        logic       pc_to_reg;
        logic       write_enable;
        logic       halt_mark;
        logic [4:0] rd;
    } wb_ctrl_t;

endpackage

// File: rtl/control_pipeline_ctrl_stage_reg.sv
// Valid-qualified control stage register: a clear or a bubble (or an invalid input)
// loads valid=0 with every control field forced to zero.
module ctrl_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         bubble,
    input  logic         valid_d,
    input  logic [W-1:0] d,
    output logic         valid_q,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clear || bubble || !valid_d) begin
            valid_q <= 1'b0;
            q       <= '0;
        end else begin
            valid_q <= 1'b1;
            q       <= d;
        end
    end

endmodule

// File: rtl/control_pipeline.sv
// Carries decoded control from ID through EX/MEM/WB, inserting bubbles on stall/flush,
// and sequences the ECALL halt (RUN -> DRAIN -> HALTED).
module control_pipeline
    import control_pipeline_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic       id_is_jal,
    input  logic       id_is_jalr,
    input  logic       id_branch,
    input  logic       id_mem_read,
    input  logic       id_mem_to_reg,
    input  logic       id_mem_write,
    input  logic       id_alu_src,
    input  logic       id_write_enable,
    input  logic       id_pc_to_reg,
    input  logic       id_is_ecall,
    input  logic [6:0] id_alu_op,
    input  logic [4:0] id_rd,
    input  logic       id_halt_cond,
    input  logic       stall,
    input  logic       flush,
    output logic       ex_valid,
    output logic       ex_is_jal,
    output logic       ex_is_jalr,
    output logic       ex_branch,
    output logic       ex_alu_src,
    output logic       ex_mem_read,
    output logic       ex_write_enable,
    output logic [6:0] ex_alu_op,
    output logic [4:0] ex_rd,
    output logic       mem_valid,
    output logic       mem_mem_read,
    output logic       mem_mem_write,
    output logic       mem_mem_to_reg,
    output logic       mem_pc_to_reg,
    output logic       mem_write_enable,
    output logic [4:0] mem_rd,
    output logic       wb_valid,
    output logic       wb_mem_to_reg,
    output logic       wb_pc_to_reg,
    output logic       wb_write_enable,
    output logic [4:0] wb_rd,
    output logic       fetch_hold,
    output logic       is_halted,
    output logic [1:0] halt_state_dbg
);

    halt_state_e state_q, state_d;
    ex_ctrl_t    ex_d, ex_q;
    mem_ctrl_t   mem_d, mem_q;
    wb_ctrl_t    wb_d, wb_q;
    logic        ex_bubble;
    logic        halt_accept;

    assign halt_accept = id_valid && id_halt_cond && !stall && !flush && (state_q == HALT_RUN);
    assign ex_bubble   = flush || stall || !id_valid || (state_q != HALT_RUN);

    // An ECALL never writes back or touches memory; the halting one carries the marker.
    always_comb begin
        ex_d              = '0;
        ex_d.is_jal       = id_is_jal;
        ex_d.is_jalr      = id_is_jalr;
        ex_d.branch       = id_branch;
        ex_d.alu_src      = id_alu_src;
        ex_d.mem_read     = id_mem_read && !id_is_ecall;
        ex_d.mem_write    = id_mem_write && !id_is_ecall;
        ex_d.mem_to_reg   = id_mem_to_reg;
        ex_d.pc_to_reg    = id_pc_to_reg;
        ex_d.write_enable = id_write_enable && !id_is_ecall && !id_halt_cond;
        ex_d.halt_mark    = id_halt_cond;
        ex_d.alu_op       = id_alu_op;
        ex_d.rd           = id_rd;
    end

    always_comb begin
        mem_d              = '0;
        mem_d.mem_read     = ex_q.mem_read;
        mem_d.mem_write    = ex_q.mem_write;
        mem_d.mem_to_reg   = ex_q.mem_to_reg;
        mem_d.pc_to_reg    = ex_q.pc_to_reg;
        mem_d.write_enable = ex_q.write_enable;
        mem_d.halt_mark    = ex_q.halt_mark;
        mem_d.rd           = ex_q.rd;
    end

    always_comb begin
        wb_d              = '0;
        wb_d.mem_to_reg   = mem_q.mem_to_reg;
        wb_d.pc_to_reg    = mem_q.pc_to_reg;
        wb_d.write_enable = mem_q.write_enable;
        wb_d.halt_mark    = mem_q.halt_mark;
        wb_d.rd           = mem_q.rd;
    end

    ctrl_stage_reg #(.W($bits(ex_ctrl_t))) u_ex (
        .clk(clk), .clear(reset), .bubble(ex_bubble), .valid_d(1'b1),
        .d(ex_d), .valid_q(ex_valid), .q(ex_q)
    );

    ctrl_stage_reg #(.W($bits(mem_ctrl_t))) u_mem (
        .clk(clk), .clear(reset), .bubble(1'b0), .valid_d(ex_valid),
        .d(mem_d), .valid_q(mem_valid), .q(mem_q)
    );

    ctrl_stage_reg #(.W($bits(wb_ctrl_t))) u_wb (
        .clk(clk), .clear(reset), .bubble(1'b0), .valid_d(mem_valid),
        .d(wb_d), .valid_q(wb_valid), .q(wb_q)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= HALT_RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HALT_RUN:    if (halt_accept) state_d = HALT_DRAIN;
            HALT_DRAIN:  if (wb_valid && wb_q.halt_mark) state_d = HALT_HALTED;
            HALT_HALTED: state_d = HALT_HALTED;
            default:     state_d = HALT_RUN;
        endcase
    end

    assign ex_is_jal        = ex_q.is_jal;
    assign ex_is_jalr       = ex_q.is_jalr;
    assign ex_branch        = ex_q.branch;
    assign ex_alu_src       = ex_q.alu_src;
    assign ex_mem_read      = ex_q.mem_read;
    assign ex_write_enable  = ex_q.write_enable;
    assign ex_alu_op        = ex_q.alu_op;
    assign ex_rd            = ex_q.rd;

    assign mem_mem_read     = mem_q.mem_read;
    assign mem_mem_write    = mem_q.mem_write;
    assign mem_mem_to_reg   = mem_q.mem_to_reg;
    assign mem_pc_to_reg    = mem_q.pc_to_reg;
    assign mem_write_enable = mem_q.write_enable;
    assign mem_rd           = mem_q.rd;

    assign wb_mem_to_reg    = wb_q.mem_to_reg;
    assign wb_pc_to_reg     = wb_q.pc_to_reg;
    assign wb_write_enable  = wb_q.write_enable;
    assign wb_rd            = wb_q.rd;

    assign fetch_hold       = (state_q != HALT_RUN);
    assign is_halted        = (state_q == HALT_HALTED);
    assign halt_state_dbg   = state_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline: per-stage checks in the driver, WB entries
// checked by a monitor against an expected queue filled at issue time.
module tb_control_pipeline;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid, id_is_jal, id_is_jalr, id_branch, id_mem_read, id_mem_to_reg;
    logic       id_mem_write, id_alu_src, id_write_enable, id_pc_to_reg, id_is_ecall;
    logic [6:0] id_alu_op;
    logic [4:0] id_rd;
    logic       id_halt_cond, stall, flush;
    logic       ex_valid, ex_is_jal, ex_is_jalr, ex_branch, ex_alu_src, ex_mem_read, ex_write_enable;
    logic [6:0] ex_alu_op;
    logic [4:0] ex_rd;
    logic       mem_valid, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_pc_to_reg, mem_write_enable;
    logic [4:0] mem_rd;
    logic       wb_valid, wb_mem_to_reg, wb_pc_to_reg, wb_write_enable;
    logic [4:0] wb_rd;
    logic       fetch_hold, is_halted;
    logic [1:0] halt_state_dbg;

    localparam int W = 8;  // {rd, write_enable, mem_to_reg, pc_to_reg}
    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           failures = 0;
    logic         model_run = 1'b1;

    control_pipeline dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_is_jal(id_is_jal),
        .id_is_jalr(id_is_jalr), .id_branch(id_branch), .id_mem_read(id_mem_read),
        .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_write_enable(id_write_enable), .id_pc_to_reg(id_pc_to_reg), .id_is_ecall(id_is_ecall),
        .id_alu_op(id_alu_op), .id_rd(id_rd), .id_halt_cond(id_halt_cond), .stall(stall),
        .flush(flush), .ex_valid(ex_valid), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_branch(ex_branch), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_write_enable(ex_write_enable), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_pc_to_reg(mem_pc_to_reg),
        .mem_write_enable(mem_write_enable), .mem_rd(mem_rd), .wb_valid(wb_valid),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_pc_to_reg(wb_pc_to_reg),
        .wb_write_enable(wb_write_enable), .wb_rd(wb_rd), .fetch_hold(fetch_hold),
        .is_halted(is_halted), .halt_state_dbg(halt_state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    logic [18:0] ex_all;
    logic [40:0] all_out;
    assign ex_all  = {ex_valid, ex_is_jal, ex_is_jalr, ex_branch, ex_alu_src, ex_mem_read,
                      ex_write_enable, ex_alu_op, ex_rd};
    assign all_out = {ex_all, mem_valid, mem_mem_read, mem_mem_write, mem_mem_to_reg,
                      mem_pc_to_reg, mem_write_enable, mem_rd, wb_valid, wb_mem_to_reg,
                      wb_pc_to_reg, wb_write_enable, wb_rd, fetch_hold, is_halted};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic set_idle();
        id_valid = 0; id_is_jal = 0; id_is_jalr = 0; id_branch = 0; id_mem_read = 0;
        id_mem_to_reg = 0; id_mem_write = 0; id_alu_src = 0; id_write_enable = 0;
        id_pc_to_reg = 0; id_is_ecall = 0; id_alu_op = '0; id_rd = '0; id_halt_cond = 0;
        stall = 0; flush = 0;
    endtask

    task automatic set_random();
        id_valid = 1'($urandom_range(0, 1)); id_is_jal = 1'($urandom_range(0, 1));
        id_is_jalr = 1'($urandom_range(0, 1)); id_branch = 1'($urandom_range(0, 1));
        id_mem_read = 1'($urandom_range(0, 1)); id_mem_to_reg = 1'($urandom_range(0, 1));
        id_mem_write = 1'($urandom_range(0, 1)); id_alu_src = 1'($urandom_range(0, 1));
        id_write_enable = 1'($urandom_range(0, 1)); id_pc_to_reg = 1'($urandom_range(0, 1));
        id_is_ecall = 1'($urandom_range(0, 1)); id_alu_op = 7'($urandom_range(0, 127));
        id_rd = 5'($urandom_range(0, 31)); id_halt_cond = 1'($urandom_range(0, 1));
        stall = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 1));
    endtask

    // Drive one ID slot for one edge; expected WB entry is queued if it will be accepted.
    task automatic step(input logic v, input logic ecall, input logic halt, input logic we,
                        input logic mr, input logic m2r, input logic mw, input logic [4:0] rd,
                        input logic [6:0] op, input logic st, input logic fl);
        id_valid = v; id_is_ecall = ecall; id_halt_cond = halt; id_write_enable = we;
        id_mem_read = mr; id_mem_to_reg = m2r; id_mem_write = mw; id_rd = rd; id_alu_op = op;
        id_alu_src = mr | mw; id_is_jal = 0; id_is_jalr = 0; id_branch = 0; id_pc_to_reg = 0;
        stall = st; flush = fl;
        if (v && !st && !fl && model_run) begin
            exp_q.push_back({rd, we & ~ecall & ~halt, m2r, 1'b0});
            if (halt) model_run = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 5'd0, 7'd0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        set_idle();
        reset = 1'b1;
        exp_q.delete();
        model_run = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    // Scoreboard monitor on the WB stage
    always @(posedge clk) begin
        #1;
        if (wb_valid) begin
            if (exp_q.size() == 0) begin
                check("wb_queue_nonempty", 64'(exp_q.size()), 64'd1);
            end else begin
                check("wb_entry", {wb_rd, wb_write_enable, wb_mem_to_reg, wb_pc_to_reg},
                      exp_q.pop_front());
            end
        end else begin
            check("wb_bubble_zero", {wb_rd, wb_write_enable, wb_mem_to_reg, wb_pc_to_reg}, 0);
        end
    end

    initial begin
        // Reset with random inputs
        set_random(); @(posedge clk); #1;
        set_random(); @(posedge clk); #1;
        check("reset_all_outputs", all_out, 0);
        check("reset_state", halt_state_dbg, 0);
        set_idle();
        reset = 1'b0;

        // Straight flow: ADD x5
        step(1, 0, 0, 1, 0, 0, 0, 5'd5, 7'h33, 0, 0);
        check("flow_ex_valid", ex_valid, 1);
        check("flow_ex_rd", ex_rd, 5);
        check("flow_ex_we", ex_write_enable, 1);
        check("flow_ex_alu_op", ex_alu_op, 7'h33);
        idle(1);
        check("flow_mem_rd", mem_rd, 5);
        check("flow_mem_we", mem_write_enable, 1);
        idle(1);
        check("flow_wb_rd", wb_rd, 5);
        check("flow_wb_we", wb_write_enable, 1);
        idle(1);

        // Load-use: LW x3, then dependent ADD x4 stalled one cycle
        step(1, 0, 0, 1, 1, 1, 0, 5'd3, 7'h03, 0, 0);
        check("lw_ex_mem_read", ex_mem_read, 1);
        step(1, 0, 0, 1, 0, 0, 0, 5'd4, 7'h33, 1, 0);
        check("stall_ex_bubble", ex_all, 0);
        check("stall_mem_mem_read", mem_mem_read, 1);
        check("stall_mem_rd", mem_rd, 3);
        step(1, 0, 0, 1, 0, 0, 0, 5'd4, 7'h33, 0, 0);
        check("after_stall_ex_valid", ex_valid, 1);
        check("after_stall_ex_rd", ex_rd, 4);
        check("lw_wb_mem_to_reg", wb_mem_to_reg, 1);
        idle(3);

        // Flush beats stall: STORE in ID is killed
        step(1, 0, 0, 0, 0, 0, 1, 5'd0, 7'h23, 1, 1);
        check("flush_ex_valid", ex_valid, 0);
        idle(1);
        check("flush_mem_write_e1", mem_mem_write, 0);
        idle(1);
        check("flush_mem_write_e2", mem_mem_write, 0);
        idle(1);

        // Halt: ADD x7 ahead of the halting ECALL
        step(1, 0, 0, 1, 0, 0, 0, 5'd7, 7'h33, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 5'd0, 7'h73, 0, 0);
        check("halt_fetch_hold", fetch_hold, 1);
        check("halt_not_yet_halted_e", is_halted, 0);
        check("halt_ecall_ex_valid", ex_valid, 1);
        check("halt_ecall_ex_we", ex_write_enable, 0);
        check("halt_add_mem_rd", mem_rd, 7);
        step(1, 0, 0, 1, 0, 0, 0, 5'd9, 7'h33, 0, 0);
        check("halt_younger_blocked", ex_valid, 0);
        check("halt_add_wb_rd", wb_rd, 7);
        check("halt_add_wb_we", wb_write_enable, 1);
        check("halt_not_yet_halted_e1", is_halted, 0);
        step(1, 0, 0, 1, 0, 0, 0, 5'd9, 7'h33, 0, 0);
        check("halt_ecall_wb_valid", wb_valid, 1);
        check("halt_ecall_wb_we", wb_write_enable, 0);
        check("halt_not_yet_halted_e2", is_halted, 0);
        step(1, 0, 0, 1, 0, 0, 0, 5'd9, 7'h33, 0, 0);
        check("halted_e3", is_halted, 1);
        check("halted_fetch_hold", fetch_hold, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 0, 0, 0, 5'(10 + i), 7'h33, 0, 0);
            check("halted_ex_valid", ex_valid, 0);
            check("halted_stays", is_halted, 1);
        end

        // Halt blocked by stall, accepted next cycle, then reset mid-DRAIN
        do_reset(1);
        check("rst2_state_run", fetch_hold, 0);
        step(1, 1, 1, 0, 0, 0, 0, 5'd0, 7'h73, 1, 0);
        check("halt_stalled_run", fetch_hold, 0);
        check("halt_stalled_ex", ex_valid, 0);
        step(1, 1, 1, 0, 0, 0, 0, 5'd0, 7'h73, 0, 0);
        check("halt_accepted_hold", fetch_hold, 1);
        check("halt_accepted_ex", ex_valid, 1);
        do_reset(1);
        check("drain_reset_all", all_out, 0);
        check("drain_reset_state", halt_state_dbg, 0);

        // Back in RUN: instructions flow again
        step(1, 0, 0, 1, 0, 0, 0, 5'd12, 7'h13, 0, 0);
        check("post_reset_ex_valid", ex_valid, 1);
        check("post_reset_ex_rd", ex_rd, 12);
        check("post_reset_not_halted", is_halted, 0);
        idle(4);
        check("queue_drained", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
